// File: rtl/serial_adder_ctrl.sv
//------------------------------------------------------------------------------
// serial_adder_ctrl : bit-serial adder controller time-sharing one full adder.
// Optional signed-overflow output enabled by macro SERIAL_ADDER_OVF_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  logic w_s0, w_c0, w_c1;

  half_adder u_ha0 (.a_i(a_i),  .b_i(b_i), .s_o(w_s0), .c_o(w_c0));
  half_adder u_ha1 (.a_i(w_s0), .b_i(c_i), .s_o(s_o),  .c_o(w_c1));

  assign c_o = w_c0 | w_c1;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
`ifdef SERIAL_ADDER_OVF_EN
  , output logic           ovf_o
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic               fa_s, fa_c;
  logic               last_bit;
  logic [WIDTH-1:0]   acc_shift;

  full_adder u_fa (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
  // LSB-first sums enter at the top, so after WIDTH shifts acc[i] holds bit i.
  assign acc_shift = {fa_s, acc_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      S_RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        acc_d   = acc_shift;
        carry_d = fa_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) begin
          state_d = S_DONE;
          sum_d   = acc_shift;
          cout_d  = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = carry_q ^ fa_c;
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if ((state_q != S_RUN) && start_i) begin
      state_d = S_RUN;
      a_sh_d  = a_i;
      b_sh_d  = b_i;
      carry_d = cin_i;
      cnt_d   = '0;
      acc_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy_o = (state_q == S_RUN);
  assign done_o = (state_q == S_DONE);
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf_o  = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
//------------------------------------------------------------------------------
// tb_serial_adder_ctrl : directed self-checking bench for serial_adder_ctrl.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             busy, done, cout;
  logic [WIDTH-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .a_i     (a),
    .b_i     (b),
    .cin_i   (cin),
    .busy_o  (busy),
    .done_o  (done),
    .sum_o   (sum),
    .cout_o  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf_o (ovf)
`endif
  );

  // Inputs change 1 time unit after the rising edge; checks read the same window.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ovf(input string tag, input logic exp);
`ifdef SERIAL_ADDER_OVF_EN
    chk(tag, {31'd0, ovf}, {31'd0, exp});
`endif
  endtask

  // One full transaction; if inj >= 0 a junk start is pulsed at that RUN cycle.
  task automatic run_add(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                         input logic ic, input int inj,
                         input logic [7:0] esum, input logic ecout, input logic eovf);
    a = ia; b = ib; cin = ic; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_nodone"}, {31'd0, done}, 32'd0);
      if (i == inj) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_sum"}, {24'd0, sum}, {24'd0, esum});
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ecout});
    chk_ovf({tag, "_ovf"}, eovf);
    step();
    chk({tag, "_pulse_end"}, {31'd0, done}, 32'd0);
    chk({tag, "_hold_sum"}, {24'd0, sum}, {24'd0, esum});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    step();
    step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum",  {24'd0, sum},  32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk_ovf("rst_ovf", 1'b0);

    // Start asserted together with reset must be ignored.
    start = 1'b1; a = 8'h12; b = 8'h34;
    step();
    chk("rst_prio_busy", {31'd0, busy}, 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    step();

    run_add("t35_4a", 8'h35, 8'h4A, 1'b0, -1, 8'h7F, 1'b0, 1'b0);
    run_add("tff_01", 8'hFF, 8'h01, 1'b0, -1, 8'h00, 1'b1, 1'b0);
    run_add("tff_00c", 8'hFF, 8'h00, 1'b1, -1, 8'h00, 1'b1, 1'b0);
    run_add("t7f_01", 8'h7F, 8'h01, 1'b0, -1, 8'h80, 1'b0, 1'b1);
    run_add("tinject", 8'h10, 8'h20, 1'b0, 3, 8'h30, 1'b0, 1'b0);
    run_add("ta5_5a", 8'hA5, 8'h5A, 1'b1, -1, 8'h00, 1'b1, 1'b0);

    // Back-to-back with start held high throughout.
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    step();
    for (int i = 0; i < WIDTH; i++) begin
      chk("b2b1_busy", {31'd0, busy}, 32'd1);
      step();
    end
    chk("b2b1_done", {31'd0, done}, 32'd1);
    chk("b2b1_sum",  {24'd0, sum},  32'h02);
    chk("b2b1_cout", {31'd0, cout}, 32'd0);
    a = 8'h80; b = 8'h80;
    step();
    chk("b2b2_busy", {31'd0, busy}, 32'd1);
    chk("b2b2_nodone", {31'd0, done}, 32'd0);
    chk("b2b2_hold", {24'd0, sum}, 32'h02);
    for (int i = 1; i < WIDTH; i++) step();
    chk("b2b2_not_early", {31'd0, done}, 32'd0);
    start = 1'b0;
    step();
    chk("b2b2_done", {31'd0, done}, 32'd1);
    chk("b2b2_sum",  {24'd0, sum},  32'h00);
    chk("b2b2_cout", {31'd0, cout}, 32'd1);
    chk_ovf("b2b2_ovf", 1'b1);
    step();
    chk("b2b2_idle", {30'd0, busy, done}, 32'd0);

    // Reset at bit 4 of a RUN discards the in-flight result.
    a = 8'h35; b = 8'h4A; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("midrst_pre_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_sum",  {24'd0, sum},  32'd0);
    chk("midrst_cout", {31'd0, cout}, 32'd0);
    chk_ovf("midrst_ovf", 1'b0);
    for (int i = 0; i < WIDTH + 2; i++) begin
      step();
      chk("midrst_no_done", {30'd0, busy, done}, 32'd0);
    end

    run_add("post_rst", 8'h01, 8'h02, 1'b1, -1, 8'h04, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
